// File: rtl/ota_cmp_monitor_if.sv
`default_nettype none
// ============================================================================
//  Module      : ota_cmp_monitor_if
//  Description : Result channel of the OTA comparator monitor. Carries the
//                per-window high-time and rising-edge counts with a
//                valid/ready handshake.
//  Revision    : 1.0  initial release
// ============================================================================
interface ota_cmp_monitor_if #(
  parameter int WIN_W = 8
);
  logic [WIN_W:0] res_high;
  logic [WIN_W:0] res_edges;
  logic           res_valid;
  logic           res_ready;

  // Producer side (the monitor)
  modport master (
    output res_high,
    output res_edges,
    output res_valid,
    input  res_ready
  );

  // Consumer side
  modport slave (
    input  res_high,
    input  res_edges,
    input  res_valid,
    output res_ready
  );
endinterface
`default_nettype wire

// File: rtl/ota_cmp_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : ota_cmp_monitor
//  Description : Synchronises and deglitches the raw comparator decision,
//                emits level/edge pulses and measures high-time and rising
//                edge count over back-to-back programmable windows.
//  Revision    : 1.0  initial release
// ============================================================================
module ota_cmp_monitor #(
  parameter int FILT_LEN = 4,
  parameter int WIN_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmp_in_i,
  input  logic              en_i,
  input  logic [WIN_W-1:0]  win_len_i,
  output logic              filt_out_o,
  output logic              rise_p_o,
  output logic              fall_p_o,
  output logic              ovr_o,
  ota_cmp_monitor_if.master res_if
);

  // Filter counter only ever needs to reach FILT_LEN (at most 15)
  localparam int               c_FCW      = 4;
  localparam logic [c_FCW-1:0] c_FILT_LEN = c_FCW'(FILT_LEN);

  localparam logic [0:0] c_IDLE = 1'b0;
  localparam logic [0:0] c_RUN  = 1'b1;

  // Synchroniser and filter state
  logic             sync1_q, sync2_q;
  logic [c_FCW-1:0] fcnt_q, fcnt_d;
  logic             filt_q, filt_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  // Window FSM and datapath state
  logic [0:0]       state_q, state_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [WIN_W-1:0] len_q, len_d;
  logic [WIN_W:0]   acc_high_q, acc_high_d;
  logic [WIN_W:0]   acc_edges_q, acc_edges_d;
  logic [WIN_W:0]   res_high_q, res_high_d;
  logic [WIN_W:0]   res_edges_q, res_edges_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  logic             w_start;
  logic             w_count;
  logic             w_close;
  logic             w_accept;
  logic [c_FCW-1:0] w_fcnt_inc;
  logic [WIN_W:0]   w_high_sum;
  logic [WIN_W:0]   w_edge_sum;

  // Two-flop synchroniser for the asynchronous comparator bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= cmp_in_i;
      sync2_q <= sync1_q;
    end
  end

  // Consecutive-disagreement filter: toggle after FILT_LEN mismatching samples
  always_comb begin
    w_fcnt_inc = fcnt_q + 1'b1;
    fcnt_d     = '0;
    filt_d     = filt_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    if (sync2_q != filt_q) begin
      if (w_fcnt_inc == c_FILT_LEN) begin
        filt_d = ~filt_q;
        rise_d = ~filt_q;
        fall_d = filt_q;
      end else begin
        fcnt_d = w_fcnt_inc;
      end
    end
  end

  // Filter registers; edge pulses update on the same edge as the level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q <= '0;
      filt_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      fcnt_q <= fcnt_d;
      filt_q <= filt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= c_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: enable starts a run, dropping enable aborts it
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE:  if (en_i)  state_d = c_RUN;
      c_RUN:   if (!en_i) state_d = c_IDLE;
      default: state_d = c_IDLE;
    endcase
  end

  // FSM outputs: window start and per-edge counting qualifiers
  always_comb begin
    w_start = 1'b0;
    w_count = 1'b0;
    case (state_q)
      c_IDLE:  w_start = en_i;
      c_RUN:   w_count = en_i;
      default: ;
    endcase
  end

  assign w_close    = w_count && (win_cnt_q == len_q);
  assign w_accept   = valid_q && res_if.res_ready;
  // Totals include the current edge: pre-edge level and a 0->1 toggle now
  assign w_high_sum = acc_high_q  + {{WIN_W{1'b0}}, filt_q};
  assign w_edge_sum = acc_edges_q + {{WIN_W{1'b0}}, rise_d};

  // Window accumulation, result capture and handshake bookkeeping
  always_comb begin
    win_cnt_d   = win_cnt_q;
    len_d       = len_q;
    acc_high_d  = acc_high_q;
    acc_edges_d = acc_edges_q;
    res_high_d  = res_high_q;
    res_edges_d = res_edges_q;
    valid_d     = valid_q;
    ovr_d       = ovr_q;

    if (w_start) begin
      win_cnt_d   = '0;
      acc_high_d  = '0;
      acc_edges_d = '0;
      len_d       = win_len_i;
      ovr_d       = 1'b0;
    end else if (w_count) begin
      if (w_close) begin
        // Next window begins on the following edge with no gap
        win_cnt_d   = '0;
        acc_high_d  = '0;
        acc_edges_d = '0;
        len_d       = win_len_i;
      end else begin
        win_cnt_d   = win_cnt_q + 1'b1;
        acc_high_d  = w_high_sum;
        acc_edges_d = w_edge_sum;
      end
    end

    if (w_close) begin
      // A consumer taking the old result on this edge frees the slot
      if (!valid_q || res_if.res_ready) begin
        res_high_d  = w_high_sum;
        res_edges_d = w_edge_sum;
        valid_d     = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (w_accept) begin
      valid_d = 1'b0;
    end
  end

  // Window datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt_q   <= '0;
      len_q       <= '0;
      acc_high_q  <= '0;
      acc_edges_q <= '0;
      res_high_q  <= '0;
      res_edges_q <= '0;
      valid_q     <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      win_cnt_q   <= win_cnt_d;
      len_q       <= len_d;
      acc_high_q  <= acc_high_d;
      acc_edges_q <= acc_edges_d;
      res_high_q  <= res_high_d;
      res_edges_q <= res_edges_d;
      valid_q     <= valid_d;
      ovr_q       <= ovr_d;
    end
  end

  assign filt_out_o       = filt_q;
  assign rise_p_o         = rise_q;
  assign fall_p_o         = fall_q;
  assign ovr_o            = ovr_q;
  assign res_if.res_high  = res_high_q;
  assign res_if.res_edges = res_edges_q;
  assign res_if.res_valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_ota_cmp_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ota_cmp_monitor
//  Description : Directed self-checking bench for ota_cmp_monitor
//                (FILT_LEN=4, WIN_W=8).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ota_cmp_monitor;

  localparam int WIN_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmp_in;
  logic             en;
  logic [WIN_W-1:0] win_len;
  logic             filt_out, rise_p, fall_p, ovr;

  int n_checks = 0;
  int n_pass   = 0;
  int sq       = 0;

  ota_cmp_monitor_if #(.WIN_W(WIN_W)) res_if ();

  ota_cmp_monitor #(.FILT_LEN(4), .WIN_W(WIN_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmp_in_i   (cmp_in),
    .en_i       (en),
    .win_len_i  (win_len),
    .filt_out_o (filt_out),
    .rise_p_o   (rise_p),
    .fall_p_o   (fall_p),
    .ovr_o      (ovr),
    .res_if     (res_if)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge
  task automatic step();
    @(negedge clk);
  endtask

  // Square wave source, period 20 (10 high / 10 low)
  task automatic sq_step();
    cmp_in = ((sq % 20) < 10);
    sq++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmp_in = 1'b0; en = 1'b0; win_len = '0;
    res_if.res_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cmp_in = ~cmp_in;
      step();
    end
    n_checks++;
    if ({filt_out, rise_p, fall_p, ovr, res_if.res_valid, res_if.res_high, res_if.res_edges} !== '0)
      $display("FAIL reset_outputs: got filt=%b rise=%b fall=%b ovr=%b valid=%b high=%0d edges=%0d, want all 0",
               filt_out, rise_p, fall_p, ovr, res_if.res_valid, res_if.res_high, res_if.res_edges);
    else n_pass++;
    cmp_in = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (3) step();
    cmp_in = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      n_checks++;
      if (filt_out !== (k >= 6))
        $display("FAIL reset_filt_latency edge %0d: got %b want %b", k, filt_out, (k >= 6));
      else n_pass++;
      n_checks++;
      if (rise_p !== (k == 6))
        $display("FAIL reset_rise_pulse edge %0d: got %b want %b", k, rise_p, (k == 6));
      else n_pass++;
    end
    cmp_in = 1'b0;
    repeat (8) step();
    n_checks++;
    if (filt_out !== 1'b0) $display("FAIL reset_filt_return: got %b want 0", filt_out);
    else n_pass++;
  endtask

  task automatic test_glitch();
    int seen, hi, nrise, rise_at, fall_at;
    seen = 0;
    cmp_in = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step();
      if (filt_out || rise_p || fall_p) seen++;
      if (k == 3) cmp_in = 1'b0;
    end
    n_checks++;
    if (seen !== 0) $display("FAIL glitch_3cyc: got %0d active samples want 0", seen);
    else n_pass++;

    hi = 0; nrise = 0; rise_at = 0; fall_at = 0;
    cmp_in = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      hi += int'(filt_out);
      if (rise_p) begin rise_at = k; nrise++; end
      if (fall_p) fall_at = k;
      if (k == 4) cmp_in = 1'b0;
    end
    n_checks++;
    if (hi !== 4) $display("FAIL glitch_4cyc_width: got %0d want 4", hi);
    else n_pass++;
    n_checks++;
    if (rise_at !== 6 || nrise !== 1)
      $display("FAIL glitch_4cyc_rise: got edge %0d count %0d want edge 6 count 1", rise_at, nrise);
    else n_pass++;
    n_checks++;
    if (fall_at !== 10) $display("FAIL glitch_4cyc_fall: got edge %0d want 10", fall_at);
    else n_pass++;
  endtask

  task automatic test_steady_window();
    int bad;
    cmp_in = 1'b1;
    repeat (8) step();
    win_len = 8'd9; res_if.res_ready = 1'b1; en = 1'b1;
    bad = 0;
    for (int k = 0; k <= 30; k++) begin
      step();
      if (res_if.res_valid !== (k > 0 && k % 10 == 0)) bad++;
      if (k == 10 || k == 20) begin
        n_checks++;
        if (res_if.res_high !== 9'd10 || res_if.res_edges !== 9'd0)
          $display("FAIL steady_data k=%0d: got high=%0d edges=%0d want 10/0",
                   k, res_if.res_high, res_if.res_edges);
        else n_pass++;
      end
    end
    n_checks++;
    if (bad !== 0) $display("FAIL steady_valid_cadence: got %0d wrong samples want 0", bad);
    else n_pass++;
    en = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_square();
    int nres;
    en = 1'b0; win_len = 8'd99; res_if.res_ready = 1'b1;
    repeat (40) sq_step();
    for (int r = 0; r < 2; r++) begin
      en = 1'b1;
      nres = 0;
      repeat (330) begin
        sq_step();
        if (res_if.res_valid) begin
          nres++;
          n_checks++;
          if (res_if.res_high !== 9'd50 || res_if.res_edges !== 9'd5)
            $display("FAIL square_data run %0d: got high=%0d edges=%0d want 50/5",
                     r, res_if.res_high, res_if.res_edges);
          else n_pass++;
        end
      end
      n_checks++;
      if (nres !== 3) $display("FAIL square_count run %0d: got %0d results want 3", r, nres);
      else n_pass++;
      en = 1'b0;
      repeat (7) sq_step();
    end
  endtask

  task automatic test_backpressure();
    cmp_in = 1'b1;
    repeat (8) step();
    win_len = 8'd9; res_if.res_ready = 1'b0; en = 1'b1;
    for (int k = 0; k <= 40; k++) begin
      step();
      if (k == 10) begin
        n_checks++;
        if (res_if.res_valid !== 1'b1 || res_if.res_high !== 9'd10)
          $display("FAIL bp_first: got valid=%b high=%0d want 1/10", res_if.res_valid, res_if.res_high);
        else n_pass++;
        cmp_in = 1'b0;
      end
      if (k == 19) begin
        n_checks++;
        if (ovr !== 1'b0) $display("FAIL bp_ovr_early: got %b want 0", ovr);
        else n_pass++;
      end
      if (k == 20) begin
        n_checks++;
        if (ovr !== 1'b1) $display("FAIL bp_ovr_set: got %b want 1", ovr);
        else n_pass++;
      end
      if (k == 24) begin
        n_checks++;
        if (res_if.res_valid !== 1'b1 || res_if.res_high !== 9'd10 || res_if.res_edges !== 9'd0)
          $display("FAIL bp_held: got valid=%b high=%0d edges=%0d want 1/10/0",
                   res_if.res_valid, res_if.res_high, res_if.res_edges);
        else n_pass++;
        res_if.res_ready = 1'b1;
      end
      if (k == 25) begin
        n_checks++;
        if (res_if.res_valid !== 1'b0) $display("FAIL bp_accept: got valid=%b want 0", res_if.res_valid);
        else n_pass++;
        res_if.res_ready = 1'b0;
      end
      if (k == 30) begin
        n_checks++;
        if (res_if.res_valid !== 1'b1 || res_if.res_high !== 9'd0 || res_if.res_edges !== 9'd0)
          $display("FAIL bp_third: got valid=%b high=%0d edges=%0d want 1/0/0",
                   res_if.res_valid, res_if.res_high, res_if.res_edges);
        else n_pass++;
        cmp_in = 1'b1;
      end
      if (k == 39) res_if.res_ready = 1'b1;
      if (k == 40) begin
        n_checks++;
        if (res_if.res_valid !== 1'b1 || res_if.res_high !== 9'd4 || res_if.res_edges !== 9'd1)
          $display("FAIL bp_coincident: got valid=%b high=%0d edges=%0d want 1/4/1",
                   res_if.res_valid, res_if.res_high, res_if.res_edges);
        else n_pass++;
      end
    end
    en = 1'b0; res_if.res_ready = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_abort();
    int bad;
    win_len = 8'd9; res_if.res_ready = 1'b1; en = 1'b1;
    step();
    n_checks++;
    if (ovr !== 1'b0) $display("FAIL abort_ovr_clear: got %b want 0", ovr);
    else n_pass++;
    repeat (5) step();
    en = 1'b0;
    bad = 0;
    repeat (15) begin
      step();
      if (res_if.res_valid !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) $display("FAIL abort_no_result: got %0d valid samples want 0", bad);
    else n_pass++;
    en = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      step();
      if (k == 9) begin
        n_checks++;
        if (res_if.res_valid !== 1'b0) $display("FAIL abort_restart_early: got valid=%b want 0", res_if.res_valid);
        else n_pass++;
      end
      if (k == 10) begin
        n_checks++;
        if (res_if.res_valid !== 1'b1 || res_if.res_high !== 9'd10 || res_if.res_edges !== 9'd0)
          $display("FAIL abort_restart_full: got valid=%b high=%0d edges=%0d want 1/10/0",
                   res_if.res_valid, res_if.res_high, res_if.res_edges);
        else n_pass++;
      end
    end
    en = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_back_to_back();
    res_if.res_ready = 1'b0; en = 1'b1;
    for (int k = 0; k <= 21; k++) begin
      step();
      if (k == 10) cmp_in = 1'b0;
      if (k == 19) res_if.res_ready = 1'b1;
      if (k == 20) begin
        n_checks++;
        if (res_if.res_valid !== 1'b1 || res_if.res_high !== 9'd6 || res_if.res_edges !== 9'd0 || ovr !== 1'b0)
          $display("FAIL b2b_load: got valid=%b high=%0d edges=%0d ovr=%b want 1/6/0/0",
                   res_if.res_valid, res_if.res_high, res_if.res_edges, ovr);
        else n_pass++;
      end
      if (k == 21) begin
        n_checks++;
        if (res_if.res_valid !== 1'b0) $display("FAIL b2b_drop: got valid=%b want 0", res_if.res_valid);
        else n_pass++;
      end
    end
    en = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_async_reset();
    cmp_in = 1'b1;
    repeat (8) step();
    res_if.res_ready = 1'b0; en = 1'b1;
    repeat (16) step();
    n_checks++;
    if (res_if.res_valid !== 1'b1 || filt_out !== 1'b1)
      $display("FAIL arst_precond: got valid=%b filt=%b want 1/1", res_if.res_valid, filt_out);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({filt_out, res_if.res_valid, ovr, res_if.res_high, res_if.res_edges} !== '0)
      $display("FAIL arst_clear: got filt=%b valid=%b ovr=%b high=%0d edges=%0d want all 0",
               filt_out, res_if.res_valid, ovr, res_if.res_high, res_if.res_edges);
    else n_pass++;
    en = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_steady_window();
    test_square();
    test_backpressure();
    test_abort();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no completion, want finish before 500000");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/ota_cmp_monitor.md
Name: ota_cmp_monitor

Overview:
- Sits directly downstream of the digital OTA/comparator cell and consumes its raw `Out` decision bit.
- Synchronises the bit into the clock domain and rejects glitches with a consecutive-sample filter.
- Emits clean level and edge pulses.
- Measures high-time and rising-edge count over programmable back-to-back windows, with results delivered through a valid/ready handshake.

Parameters:
- FILT_LEN, 4: consecutive synchronised samples that must disagree with the filtered level before it toggles (legal 2..15).
- WIN_W, 8: width of the window-length field; window length 1..2^WIN_W cycles.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmp_in  in  1  raw comparator decision, asynchronous to clk.
- en  in  1  run enable for window measurement.
- win_len  in  WIN_W  window length minus one; latched at each window start.
- filt_out  out  1  filtered comparator level.
- rise_p  out  1  one-cycle pulse on filt_out 0->1.
- fall_p  out  1  one-cycle pulse on filt_out 1->0.
- res_high  out  WIN_W+1  count of cycles filt_out was 1 in the last completed window.
- res_edges  out  WIN_W+1  rising edges of filt_out in the last completed window.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- ovr  out  1  sticky overrun: a completed window was dropped.

Behaviour:
Reset:
- Every flop and output resets to 0, including both synchroniser stages, filt_out, pulses, counters, results, res_valid and ovr.
- State resets to IDLE.

Synchroniser:
- Two flops; the sampled value is s2.

Filter:
- A counter increments on each edge where s2 != filt_out and clears when s2 == filt_out.
- When the counter would reach FILT_LEN, filt_out toggles and the counter clears.
- Input change to filt_out change is FILT_LEN+2 edges.
- A pulse narrower than FILT_LEN cycles never propagates.
- rise_p and fall_p are registered on the same edge filt_out changes and last exactly 1 cycle.

FSM states:
- IDLE -> RUN on an edge with en=1. On that edge: win_cnt, acc_high and acc_edges clear, win_len is latched, and ovr clears.
- RUN -> IDLE on any edge with en=0. The partial window is discarded and no result is produced; res_valid/res data already held are unaffected.

Counting in RUN, each edge:
- acc_high += filt_out (pre-edge value).
- acc_edges += 1 if filt_out transitions 0->1 on this edge.
- win_cnt += 1.

Window close:
- Happens on the edge where win_cnt == latched win_len. Totals include that edge's contribution, so the window is exactly win_len+1 edges.
- On close: load res_high/res_edges, set res_valid, clear the accumulators and win_cnt, and re-latch win_len. The next window starts immediately with no gap cycle.
- Arithmetic is unsigned, WIN_W+1 bits; maximum value 2^WIN_W, which cannot overflow.

Handshake:
- res_valid && res_ready at an edge clears res_valid.
- res_high/res_edges are stable while res_valid=1.
- Close while res_valid=1 and res_ready=0: the new result is dropped, held data is kept, and ovr is set (sticky until the next IDLE->RUN or reset).
- Close on the same edge as acceptance: the new result loads, res_valid stays 1, and no overrun is flagged.

Async reset mid-window:
- Immediately returns all state to reset values; no partial result is produced.

Test Plan (FILT_LEN=4, WIN_W=8):
1. Reset
   - Stimulus: assert rst_n=0 with cmp_in=1 toggling.
   - Required: all outputs 0; after release, filt_out rises exactly 6 edges after cmp_in is held high; rise_p high for 1 cycle.
2. Glitch rejection
   - Stimulus: cmp_in high for 3 cycles, then low.
   - Required: filt_out stays 0; no rise_p or fall_p.
   - Stimulus: high for 4 cycles.
   - Required: filt_out 1 for 4 cycles, rise_p then fall_p.
3. Steady-high window
   - Stimulus: filt_out=1, en=1, win_len=9.
   - Required: res_valid after 10 RUN edges with res_high=10, res_edges=0.
   - Required: consecutive windows (res_ready=1) repeat every 10 cycles.
4. Square wave
   - Stimulus: cmp_in period 20 (10 high / 10 low), win_len=99, res_ready=1.
   - Required: every result is res_high=50, res_edges=5, independent of phase.
5. Backpressure
   - Stimulus: win_len=9, res_ready=0 for 25 cycles.
   - Required: first result held; second window dropped; ovr=1.
   - Stimulus: res_ready=1.
   - Required: res_valid drops next edge unless a close coincides.
   - Stimulus: close on the acceptance edge.
   - Required: new data loads with no ovr.
6. Abort
   - Stimulus: en=0 at win_cnt=5.
   - Required: no res_valid; state IDLE.
   - Stimulus: en=1 again.
   - Required: ovr clears and the next window counts a full win_len+1 edges from zero.
